uart_cmd_rcv: RTL
=================

# uart_cmd_rcv

Serial command receiver between the CommMaster TX line and the MazeRunner command processor. It deserializes 8N1 UART frames from `RX` and assembles two consecutive bytes, high byte first, into a 16-bit travel-plan command. It presents the command with a `cmd_rdy`/`clr_cmd_rdy` handshake. It also detects framing errors, inter-byte timeouts and overruns, so a corrupted or partial command never reaches the command processor.

## Interface
- `BAUD_DIV`, default 2604: clock cycles per bit period. Minimum 4.
- `TIMEOUT_BITS`, default 32: maximum bit periods allowed between the high byte's stop sample and the low byte's start edge.
- `clk`  input  1  system clock.
- `rst`  input  1  reset, synchronous and active-high.
- `RX`  input  1  asynchronous serial line; idles high.
- `clr_cmd_rdy`  input  1  consumer acknowledge; clears `cmd_rdy`.
- `cmd`  output  16  last assembled command; holds its value until the next complete command.
- `cmd_rdy`  output  1  a valid command is waiting.
- `frm_err`  output  1  one-cycle pulse on a bad stop bit.
- `ovr_err`  output  1  one-cycle pulse when a command completes while `cmd_rdy` is already high.

## Operation
- **Reset values:** `cmd`=0, `cmd_rdy`=0, `frm_err`=0, `ovr_err`=0.
- **Reset state:** synchronizer flops=1, receiver FSM=IDLE, assembler=WAIT_HI.
- **Reset mid-frame:** abandons any frame in progress.
- **RX synchronization:** two flops. Edge detection and sampling use only the second flop (`rx_s`).
- **Receiver FSM:**
  - IDLE: on `rx_s` falling (1 to 0), load `baud_cnt`=BAUD_DIV/2 (integer division) and go to START.
  - START: when `baud_cnt` reaches 0, sample `rx_s`. If 1 (glitch), return to IDLE with no error. If 0, go to DATA with `bit_cnt`=0 and `baud_cnt`=BAUD_DIV.
  - DATA: sample each time `baud_cnt` reaches 0, then reload. Bits shift in LSB first. After 8 samples, go to STOP.
  - STOP: sample after BAUD_DIV cycles. If 1, set `byte_done` for one cycle. If 0, pulse `frm_err`. Either way return to IDLE.
  - A falling edge seen in IDLE in the same cycle as the STOP sample is legal back-to-back framing.
- **Byte assembler:**
  - WAIT_HI: on `byte_done`, store `hi_byte`, start the timeout counter (TIMEOUT_BITS×BAUD_DIV cycles) and go to WAIT_LO.
  - WAIT_LO, low byte arrives: on `byte_done`, set `cmd`={hi_byte, byte} and `cmd_rdy`=1. If `cmd_rdy` was already 1, pulse `ovr_err`; the new value overwrites the old one. Return to WAIT_HI.
  - WAIT_LO, timeout: if the counter expires before the low byte's start edge, discard `hi_byte` and return to WAIT_HI. No error pulse. The counter stops at the start edge.
  - Framing error in any state: return the assembler to WAIT_HI and discard the partial command.
- **Handshake:**
  - `clr_cmd_rdy` clears `cmd_rdy` on the next edge.
  - If `clr_cmd_rdy` coincides with completion of a new command, set wins: `cmd_rdy` stays 1, `cmd` updates, and no `ovr_err` is raised.
  - `cmd` never changes except on command completion.
- **Counter widths:**
  - `baud_cnt`: width $clog2(BAUD_DIV+1).
  - Timeout counter: width $clog2(TIMEOUT_BITS×BAUD_DIV+1).
  - Both counters saturate at 0 and never wrap.

## Timing
- **Start-bit check:** the start edge appears on `rx_s` 2 cycles after `RX` falls. START samples BAUD_DIV/2 cycles later.
- **Data sampling:** bit n (0-7) is sampled at BAUD_DIV/2 + (n+1)×BAUD_DIV cycles after the `rx_s` edge. The stop bit is sampled at BAUD_DIV/2 + 9×BAUD_DIV.
- **`byte_done`:** internal, asserted the cycle after the stop sample.
- **Command output:** `cmd`/`cmd_rdy` update on the clock edge after the low byte's `byte_done`. The latency from the low byte's stop-sample edge to `cmd_rdy`=1 is 2 cycles.
- **Error pulses:** `frm_err` and `ovr_err` are exactly 1 cycle wide and registered.
- **Frame length:** a complete command with zero inter-byte gap takes 20×BAUD_DIV cycles on the line.

## Test plan
- Reset, `RX`=1 idle, BAUD_DIV=2604: send 0xAA then 0xAA -> `cmd`=16'hAAAA, `cmd_rdy`=1; assert `clr_cmd_rdy` for 1 cycle -> `cmd_rdy`=0 next cycle, `cmd` holds 16'hAAAA.
- Send 0x00 then 0x03 back-to-back with zero idle between frames -> `cmd`=16'h0003. Repeat with 0xFF,0xFF without clearing -> `cmd`=16'hFFFF and one `ovr_err` pulse.
- Drive `RX` low for BAUD_DIV/4 cycles (start glitch) -> no state change, no error; then send 0x12,0x34 -> `cmd`=16'h1234.
- Send 0x12, then a frame with stop bit 0, then 0x56,0x78 -> one `frm_err` pulse, `cmd`=16'h5678, never 16'h12xx.
- Send 0x12, idle for 40 bit periods, then send 0x34,0x56 -> `cmd`=16'h3456.
- Complete a command on the same cycle `clr_cmd_rdy`=1 -> `cmd_rdy` stays 1 with the new `cmd`, no `ovr_err`. Assert `rst` midway through a high byte -> all outputs at reset values; the next 2-byte command is received correctly.

Source files
------------

// File: rtl/uart_cmd_rcv.sv
// 8N1 UART receiver that assembles two bytes (high byte first) into a 16-bit command
// with a cmd_rdy/clr_cmd_rdy handshake, framing-error, inter-byte timeout and overrun detection.
module uart_cmd_rcv #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err,
    output logic        ovr_err,
    output logic [2:0]  dbg_state
);

    localparam int BW  = $clog2(BAUD_DIV + 1);
    localparam int TMO = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW  = $clog2(TMO + 1);
    // Counters are loaded with N-1 so that the sample lands exactly N cycles later.
    localparam logic [BW-1:0] HALF_M1 = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TMO - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

    rx_state_t  rx_state, rx_next;
    asm_state_t asm_state, asm_next;

    logic          rx_meta, rx_s, rx_s_d;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          byte_done;
    logic [7:0]    hi_byte;
    logic [TW-1:0] tmo_cnt;

    logic fall, baud_zero, load_half, sample, shift_en, stop_ok, stop_bad;
    logic tmo_run, tmo_expire, capture_hi, complete;

    assign fall      = rx_s_d & ~rx_s;
    assign baud_zero = (baud_cnt == '0);
    assign dbg_state = {asm_state, rx_state};

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Receiver FSM: state register / next state / outputs
    always_ff @(posedge clk) begin
        if (rst) rx_state <= IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (fall) rx_next = START;
            START: if (baud_zero) rx_next = rx_s ? IDLE : DATA;
            DATA:  if (baud_zero && bit_cnt == 3'd7) rx_next = STOP;
            STOP:  if (baud_zero) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_comb begin
        load_half = (rx_state == IDLE) && fall;
        sample    = (rx_state != IDLE) && baud_zero;
        shift_en  = (rx_state == DATA) && baud_zero;
        stop_ok   = (rx_state == STOP) && baud_zero && rx_s;
        stop_bad  = (rx_state == STOP) && baud_zero && !rx_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            byte_done <= stop_ok;
            frm_err   <= stop_bad;
            if (load_half)      baud_cnt <= HALF_M1;
            else if (sample)    baud_cnt <= FULL_M1;
            else if (!baud_zero) baud_cnt <= baud_cnt - BW'(1);
            if (rx_state == START) bit_cnt <= '0;
            if (shift_en) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Byte assembler FSM: state register / next state / outputs
    always_ff @(posedge clk) begin
        if (rst) asm_state <= WAIT_HI;
        else     asm_state <= asm_next;
    end

    always_comb begin
        asm_next = asm_state;
        case (asm_state)
            WAIT_HI: if (byte_done) asm_next = WAIT_LO;
            WAIT_LO: if (frm_err || byte_done || tmo_expire) asm_next = WAIT_HI;
            default: asm_next = WAIT_HI;
        endcase
    end

    // The timeout only runs while the line is idle, so it freezes at the low byte's start edge.
    always_comb begin
        tmo_run    = (asm_state == WAIT_LO) && (rx_state == IDLE) && !fall;
        tmo_expire = tmo_run && (tmo_cnt == '0);
        capture_hi = (asm_state == WAIT_HI) && byte_done;
        complete   = (asm_state == WAIT_LO) && byte_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_byte <= '0;
            tmo_cnt <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            if (capture_hi) begin
                hi_byte <= shreg;
                tmo_cnt <= TMO_M1;
            end else if (tmo_run && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TW'(1);
            end
            ovr_err <= 1'b0;
            // Completion wins over a simultaneous clear; that case is not an overrun.
            if (complete) begin
                cmd     <= {hi_byte, shreg};
                cmd_rdy <= 1'b1;
                ovr_err <= cmd_rdy && !clr_cmd_rdy;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

endmodule
